// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel tick generator: clock default, standard rates
// and the channel roles used by the CHIP-8 core.
`ifndef CLOCK_SPEED
`define CLOCK_SPEED 50_000_000
`endif

package multi_timer_pkg;

   localparam int unsigned CLOCK_HZ_DEF = `CLOCK_SPEED;
   localparam int unsigned CPU_HZ       = 500;
   localparam int unsigned TICK_60HZ    = 60;

   // Channel roles: instruction pacing and the 60 Hz delay/sound decrement.
   localparam int unsigned CH_CPU  = 0;
   localparam int unsigned CH_60HZ = 1;

endpackage

// File: rtl/multi_timer_if.sv
// Config bus, per-channel controls and tick outputs of multi_timer.
// The master side (CPU/debugger) drives controls; the slave (timer) returns ticks/status.
interface multi_timer_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32,
   parameter int CH_W   = 1
);
   logic              cfg_we;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] ch_oneshot;
   logic [NUM_CH-1:0] restart;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] ch_active;

   modport master (
      output cfg_we, cfg_ch, cfg_div, ch_en, ch_oneshot, restart,
      input  tick, ch_active
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_div, ch_en, ch_oneshot, restart,
      output tick, ch_active
   );
endinterface

// File: rtl/multi_timer_tick_channel.sv
// One tick channel: divisor register, down-counter, armed flag, registered tick.
// Tick rises d cycles after a restart edge; no backpressure, ticks are single-cycle pulses.
module tick_channel #(
   parameter int              CNT_W       = 32,
   parameter logic [CNT_W-1:0] DEF_DIV_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_we,
   input  logic [CNT_W-1:0] div_wdat,
   input  logic             en,
   input  logic             oneshot,
   input  logic             restart,
   output logic             tick,
   output logic             active
);
   function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   localparam logic [CNT_W-1:0] RST_CNT = eff_div(DEF_DIV_VAL) - CNT_W'(1);

   logic [CNT_W-1:0] div_q;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             armed_q, armed_nxt;
   logic             tick_nxt;

   always_comb begin
      cnt_nxt   = cnt_q;
      armed_nxt = armed_q;
      tick_nxt  = 1'b0;
      if (restart) begin
         // A divisor written in the same cycle applies to this reload.
         cnt_nxt   = (div_we ? eff_div(div_wdat) : eff_div(div_q)) - CNT_W'(1);
         armed_nxt = 1'b1;
      end else if (en && armed_q) begin
         if (cnt_q == '0) begin
            tick_nxt = 1'b1;
            cnt_nxt  = eff_div(div_q) - CNT_W'(1);
            if (oneshot) armed_nxt = 1'b0;
         end else begin
            cnt_nxt = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= DEF_DIV_VAL;
         cnt_q   <= RST_CNT;
         armed_q <= 1'b1;
         tick    <= 1'b0;
      end else begin
         if (div_we) div_q <= div_wdat;
         cnt_q   <= cnt_nxt;
         armed_q <= armed_nxt;
         tick    <= tick_nxt;
      end
   end

   assign active = armed_q;
endmodule

// File: rtl/multi_timer.sv
// Multi-channel programmable tick generator; each channel ticks every max(div,1) cycles.
// Outputs are registered, one cycle per tick; no backpressure, cfg writes always accepted.
module multi_timer
   import multi_timer_pkg::*;
#(
   parameter int unsigned CLOCK_HZ = CLOCK_HZ_DEF,
   parameter int          NUM_CH   = 2,
   parameter int          CNT_W    = 32,
   parameter int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV =
      {CNT_W'(CLOCK_HZ / TICK_60HZ), CNT_W'(CLOCK_HZ / CPU_HZ)}
) (
   input logic           clk,
   input logic           rst_n,
   multi_timer_if.slave  bus
);
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Out-of-range channel selects match no channel and are dropped.
      logic div_we;
      assign div_we = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

      tick_channel #(
         .CNT_W       (CNT_W),
         .DEF_DIV_VAL (DEF_DIV[i*CNT_W +: CNT_W])
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .div_we   (div_we),
         .div_wdat (bus.cfg_div),
         .en       (bus.ch_en[i]),
         .oneshot  (bus.ch_oneshot[i]),
         .restart  (bus.restart[i]),
         .tick     (bus.tick[i]),
         .active   (bus.ch_active[i])
      );
   end
endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: two channels, 8-bit counters, defaults ch0=3, ch1=4.
module tb_multi_timer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   n;

   always #5 clk = ~clk;

   multi_timer_if #(.NUM_CH(2), .CNT_W(8), .CH_W(2)) bus ();

   multi_timer #(
      .CLOCK_HZ (1000),
      .NUM_CH   (2),
      .CNT_W    (8),
      .CH_W     (2),
      .DEF_DIV  ({8'd4, 8'd3})
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.cfg_we     = 1'b0;
      bus.cfg_ch     = 2'd0;
      bus.cfg_div    = 8'd0;
      bus.ch_en      = 2'b11;
      bus.ch_oneshot = 2'b00;
      bus.restart    = 2'b00;

      #23;
      chk("rst_tick", 8'(bus.tick), 8'h0);
      chk("rst_active", 8'(bus.ch_active), 8'h3);
      #9 rst_n = 1'b1;

      // Free-run from reset: ch0 every 3 edges, ch1 every 4.
      for (int k = 1; k <= 12; k++) begin
         step();
         chk("t1_free", 8'({bus.ch_active, (k % 4 == 0), (k % 3 == 0)}),
             8'({2'b11, (k % 4 == 0) ? 1'b1 : 1'b0, (k % 3 == 0) ? 1'b1 : 1'b0}));
      end

      // One-shot on ch1.
      bus.ch_oneshot = 2'b10;
      bus.restart    = 2'b10;
      step();
      bus.restart = 2'b00;
      chk("t2_restart", 8'(bus.tick[1]), 8'h0);
      for (int j = 1; j <= 4; j++) begin
         step();
         chk("t2_shot", 8'(bus.tick[1]), (j == 4) ? 8'h1 : 8'h0);
      end
      chk("t2_disarm", 8'(bus.ch_active[1]), 8'h0);
      n = 0;
      repeat (50) begin
         step();
         n += int'(bus.tick[1]);
      end
      chk("t2_quiet", 8'(n), 8'h0);
      bus.restart = 2'b10;
      step();
      bus.restart = 2'b00;
      chk("t2_rearm", 8'(bus.ch_active[1]), 8'h1);
      for (int j = 1; j <= 4; j++) begin
         step();
         chk("t2_shot2", 8'(bus.tick[1]), (j == 4) ? 8'h1 : 8'h0);
      end
      chk("t2_disarm2", 8'(bus.ch_active[1]), 8'h0);

      // Divisor change mid-count: old schedule finishes, then period 5.
      bus.restart = 2'b01;
      step();
      bus.restart = 2'b00;
      for (int j = 1; j <= 13; j++) begin
         step();
         chk("t3_div", 8'(bus.tick[0]), (j == 3 || j == 8 || j == 13) ? 8'h1 : 8'h0);
         if (j == 1) begin
            bus.cfg_we  = 1'b1;
            bus.cfg_ch  = 2'd0;
            bus.cfg_div = 8'd5;
         end
         if (j == 2) bus.cfg_we = 1'b0;
      end

      // Divisor 0 written with a same-cycle restart -> tick every cycle.
      bus.cfg_we  = 1'b1;
      bus.cfg_ch  = 2'd0;
      bus.cfg_div = 8'd0;
      bus.restart = 2'b01;
      step();
      bus.cfg_we  = 1'b0;
      bus.restart = 2'b00;
      chk("t3_zero_rst", 8'(bus.tick[0]), 8'h0);
      for (int j = 1; j <= 5; j++) begin
         step();
         chk("t3_zero", 8'(bus.tick[0]), 8'h1);
      end

      // Write to nonexistent channel 3 must leave both channels alone.
      bus.cfg_we  = 1'b1;
      bus.cfg_ch  = 2'd3;
      bus.cfg_div = 8'd9;
      step();
      bus.cfg_we = 1'b0;
      for (int j = 1; j <= 4; j++) begin
         step();
         chk("t3_badch0", 8'(bus.tick[0]), 8'h1);
      end
      bus.ch_oneshot = 2'b00;
      bus.restart    = 2'b10;
      step();
      bus.restart = 2'b00;
      for (int j = 1; j <= 8; j++) begin
         step();
         chk("t3_badch1", 8'(bus.tick), 8'({(j % 4 == 0) ? 1'b1 : 1'b0, 1'b1}));
      end

      // Pause at cnt=1, resume; then restart on terminal count; then slow divisor.
      bus.cfg_we  = 1'b1;
      bus.cfg_ch  = 2'd0;
      bus.cfg_div = 8'd3;
      bus.restart = 2'b01;
      step();
      bus.cfg_we  = 1'b0;
      bus.restart = 2'b00;
      for (int j = 1; j <= 22; j++) begin
         step();
         chk("t4_t5_sched", 8'(bus.tick[0]),
             (j == 13 || j == 16 || j == 22) ? 8'h1 : 8'h0);
         if (j == 1)  bus.ch_en = 2'b10;
         if (j == 5)  chk("t4_pause_active", 8'(bus.ch_active[0]), 8'h1);
         if (j == 11) bus.ch_en = 2'b11;
         if (j == 18) bus.restart = 2'b01;
         if (j == 19) begin
            bus.restart = 2'b00;
            bus.cfg_we  = 1'b1;
            bus.cfg_ch  = 2'd0;
            bus.cfg_div = 8'd7;
         end
         if (j == 20) bus.cfg_we = 1'b0;
      end

      // Asynchronous reset mid-cycle while ch0 tick is high.
      #2 rst_n = 1'b0;
      #1;
      chk("t5_arst_tick", 8'(bus.tick), 8'h0);
      chk("t5_arst_active", 8'(bus.ch_active), 8'h3);
      step();
      step();
      chk("t5_hold_tick", 8'(bus.tick), 8'h0);
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("t5_post", 8'({bus.ch_active, (k % 4 == 0), (k % 3 == 0)}),
             8'({2'b11, (k % 4 == 0) ? 1'b1 : 1'b0, (k % 3 == 0) ? 1'b1 : 1'b0}));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
